div_freq: RTL and testbench



---
 rtl/div_freq.sv | 87 ++++++++
 tb/tb_div_freq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/div_freq.sv
// -----------------------------------------------------------------------------
// div_freq
//   Programmable clock-enable divider producing the PCM serial bit clock bclk
//   from the system clock clk. bclk is a registered square wave that advances
//   one count per clk edge on which en_clk is high. Single-cycle rise/fall
//   strobes let downstream samplers stay in the clk domain.
//
// Parameters
//   DIV_HALF : enabled clk cycles per bclk half-period (legal 1..65535)
//
// Ports
//   clk       in  : system clock, rising edge, the only clock
//   reset     in  : asynchronous, active-high reset
//   en_clk    in  : count enable
//   bclk      out : divided bit clock, registered
//   bclk_rise out : one-clk pulse in the cycle bclk becomes 1
//   bclk_fall out : one-clk pulse in the cycle bclk becomes 0
//
// Configuration macro
//   DIVFREQ_GATE_IDLE_LOW_EN : when defined, en_clk=0 clears the counter and
//     parks bclk low (microphone idle); a falling strobe is emitted if bclk
//     was high. When undefined, en_clk=0 simply freezes counter and bclk.
// -----------------------------------------------------------------------------
module div_freq #(
    parameter int DIV_HALF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en_clk,
    output logic bclk,
    output logic bclk_rise,
    output logic bclk_fall
);

    // Counter only has to hold 0..DIV_HALF-1; keep at least one bit.
    localparam int CNT_W = (DIV_HALF < 2) ? 1 : $clog2(DIV_HALF + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_HALF - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_bclk;
    logic             r_rise;
    logic             r_fall;
    logic             w_last;

    // The compare is the only wrap path, so r_cnt never exceeds LAST.
    assign w_last = (r_cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, e.g. the strobes below read the old r_bclk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_bclk <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else if (en_clk) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_last) begin
                r_cnt  <= '0;
                r_bclk <= ~r_bclk;
                // Strobe matches the direction of the toggle being made now.
                r_rise <= ~r_bclk;
                r_fall <= r_bclk;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
`ifdef DIVFREQ_GATE_IDLE_LOW_EN
            // Idle: restart a fresh low half-period once enable returns.
            r_cnt  <= '0;
            r_bclk <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= r_bclk;
`else
            // Paused: counter and bclk hold, stretching the half-period.
            r_rise <= 1'b0;
            r_fall <= 1'b0;
`endif
        end
    end

    assign bclk      = r_bclk;
    assign bclk_rise = r_rise;
    assign bclk_fall = r_fall;

endmodule

// File: tb/tb_div_freq.sv
// -----------------------------------------------------------------------------
// tb_div_freq
//   Self-checking bench for div_freq. Three instances (DIV_HALF = 2, 1, 5)
//   share clk, reset and en_clk. A reference model derives bclk from the total
//   number of enabled edges since reset: bclk = (k / DIV_HALF) % 2, with the
//   strobes marking its transitions. Hand tables cover the free run, pause /
//   idle behaviour and asynchronous reset; a random enable run covers the rest.
// -----------------------------------------------------------------------------
module tb_div_freq;

    logic clk;
    logic reset;
    logic en_clk;
    logic b2, r2, f2;
    logic b1, r1, f1;
    logic b5, r5, f5;

    int total = 0;
    int bad   = 0;
    int max_cnt5 = 0;

    div_freq #(.DIV_HALF(2)) u2 (.clk(clk), .reset(reset), .en_clk(en_clk),
                                 .bclk(b2), .bclk_rise(r2), .bclk_fall(f2));
    div_freq #(.DIV_HALF(1)) u1 (.clk(clk), .reset(reset), .en_clk(en_clk),
                                 .bclk(b1), .bclk_rise(r1), .bclk_fall(f1));
    div_freq #(.DIV_HALF(5)) u5 (.clk(clk), .reset(reset), .en_clk(en_clk),
                                 .bclk(b5), .bclk_rise(r5), .bclk_fall(f5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int   dv [3] = '{2, 1, 5};
    int   k  [3];
    logic mb [3];
    logic mr [3];
    logic mf [3];

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            k[i] = 0; mb[i] = 1'b0; mr[i] = 1'b0; mf[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge(input logic e);
        logic prev;
        for (int i = 0; i < 3; i++) begin
            prev = mb[i];
            if (e) k[i] = k[i] + 1;
`ifdef DIVFREQ_GATE_IDLE_LOW_EN
            else k[i] = 0;
`endif
            mb[i] = ((k[i] / dv[i]) % 2) == 1;
            mr[i] = !prev && mb[i];
            mf[i] = prev && !mb[i];
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        check($sformatf("%s/d2", tag), {29'b0, b2, r2, f2}, {29'b0, mb[0], mr[0], mf[0]});
        check($sformatf("%s/d1", tag), {29'b0, b1, r1, f1}, {29'b0, mb[1], mr[1], mf[1]});
        check($sformatf("%s/d5", tag), {29'b0, b5, r5, f5}, {29'b0, mb[2], mr[2], mf[2]});
    endtask

    // One clk edge: update model with the inputs present at the edge, sample 1ns later.
    task automatic tick(input string tag);
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge(en_clk);
        #1;
        if (int'(u5.r_cnt) > max_cnt5) max_cnt5 = int'(u5.r_cnt);
        compare_all(tag);
    endtask

    // Assert reset between edges and confirm outputs clear before the next edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        check({tag, "/b2_now"}, {31'b0, b2}, 32'd0);
        tick({tag, "_held"});
        reset = 1'b0;
    endtask

    typedef struct {
        logic       en;
        logic [2:0] exp2;   // {bclk, rise, fall} of the DIV_HALF=2 instance
    } vec_t;

    vec_t run_tbl [10];
    vec_t pause_tbl [10];

    initial begin
        // Free run, DIV_HALF=2: rise on edges 2,6,10, fall on 4,8.
        for (int i = 0; i < 10; i++) begin
            run_tbl[i].en   = 1'b1;
            run_tbl[i].exp2 = 3'b000;
        end
        run_tbl[1].exp2 = 3'b110; run_tbl[2].exp2 = 3'b100;
        run_tbl[3].exp2 = 3'b001;
        run_tbl[5].exp2 = 3'b110; run_tbl[6].exp2 = 3'b100;
        run_tbl[7].exp2 = 3'b001;
        run_tbl[9].exp2 = 3'b110;

        // Enable pause one edge after the first rise (edges 4..8 disabled).
        for (int i = 0; i < 10; i++) pause_tbl[i].en = !(i >= 3 && i <= 7);
        pause_tbl[0].exp2 = 3'b000;
        pause_tbl[1].exp2 = 3'b110;
        pause_tbl[2].exp2 = 3'b100;
`ifdef DIVFREQ_GATE_IDLE_LOW_EN
        pause_tbl[3].exp2 = 3'b001;
        for (int i = 4; i < 9; i++) pause_tbl[i].exp2 = 3'b000;
        pause_tbl[9].exp2 = 3'b110;
`else
        for (int i = 3; i < 8; i++) pause_tbl[i].exp2 = 3'b100;
        pause_tbl[8].exp2 = 3'b001;
        pause_tbl[9].exp2 = 3'b000;
`endif

        // ---- reset held with en_clk high: nothing moves ----
        reset  = 1'b1;
        en_clk = 1'b1;
        model_reset();
        #2;
        compare_all("rst_initial");
        for (int i = 0; i < 3; i++) begin
            tick($sformatf("rst_hold%0d", i));
            check($sformatf("rst_hold%0d/d2_zero", i), {29'b0, b2, r2, f2}, 32'd0);
        end
        reset = 1'b0;

        // ---- free run table; DIV_HALF=1 toggles every edge ----
        for (int i = 0; i < 10; i++) begin
            en_clk = run_tbl[i].en;
            tick($sformatf("run%0d", i + 1));
            check($sformatf("run%0d/tbl_d2", i + 1), {29'b0, b2, r2, f2}, {29'b0, run_tbl[i].exp2});
            check($sformatf("run%0d/tbl_d1", i + 1), {29'b0, b1, r1, f1},
                  {29'b0, ((i + 1) % 2 == 1), ((i + 1) % 2 == 1), ((i + 1) % 2 == 0)});
        end

        // ---- bclk of the DIV_HALF=2 instance is high here: reset must clear it at once ----
        async_reset("arst_high");

        // ---- enable pause / idle sequence ----
        for (int i = 0; i < 10; i++) begin
            en_clk = pause_tbl[i].en;
            tick($sformatf("pause%0d", i + 1));
            check($sformatf("pause%0d/tbl_d2", i + 1), {29'b0, b2, r2, f2}, {29'b0, pause_tbl[i].exp2});
        end

        // ---- random enable pattern against the model, with a reset in the middle ----
        for (int n = 0; n < 400; n++) begin
            en_clk = ($urandom_range(0, 3) != 0);
            tick("rand");
            if (n == 200) async_reset("arst_rand");
        end

        // DIV_HALF=5 counter walks to 4 and never beyond.
        check("d5_cnt_max", max_cnt5, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
